// File: rtl/imem_loader_if.sv
// Control, byte-stream and instruction-memory write-port bundle for imem_loader.
// The host/boot side is the master; the loader is the slave.
interface imem_loader_if #(
  parameter int ADDR_W = 6
);
  logic              start;
  logic [ADDR_W:0]   word_count;
  logic              abort;
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              busy;
  logic              done;
  logic              error;

  modport master (
    output start, word_count, abort, byte_in, byte_valid,
    input  byte_ready, mem_we, mem_addr, mem_wdata, busy, done, error
  );

  modport slave (
    input  start, word_count, abort, byte_in, byte_valid,
    output byte_ready, mem_we, mem_addr, mem_wdata, busy, done, error
  );
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory loader: packs a valid/ready byte stream into little-endian
// 32-bit words and writes them to consecutive addresses from 0, holding busy meanwhile.
module imem_loader #(
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64
) (
  input  logic         clock,
  input  logic         reset_,
  imem_loader_if.slave bus
);
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] MAX_COUNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;

  state_t            state;
  logic [CNT_W-1:0]  count_q;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        byte_idx;
  logic [31:0]       word_q;

  logic count_ok;
  logic last_word;
  logic accept;

  assign count_ok  = (bus.word_count != '0) && (bus.word_count <= MAX_COUNT);
  assign last_word = ({1'b0, addr_q} == (count_q - CNT_W'(1)));
  assign accept    = bus.byte_valid && bus.byte_ready;

  // NOTE: every register here uses <= so all updates see pre-edge values;
  // a blocking write would leak into later reads within the same edge.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      // NOTE: reset is asynchronous so an in-flight mem_we strobe is killed
      // immediately rather than at the next edge.
      state          <= IDLE;
      count_q        <= '0;
      addr_q         <= '0;
      byte_idx       <= '0;
      word_q         <= '0;
      bus.byte_ready <= 1'b0;
      bus.mem_we     <= 1'b0;
      bus.mem_addr   <= '0;
      bus.mem_wdata  <= '0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.error      <= 1'b0;
    end else begin
      bus.mem_we <= 1'b0;
      bus.done   <= 1'b0;
      bus.error  <= 1'b0;

      unique case (state)
        IDLE: begin
          bus.busy       <= 1'b0;
          bus.byte_ready <= 1'b0;
          if (bus.start) begin
            if (count_ok) begin
              count_q        <= bus.word_count;
              addr_q         <= '0;
              byte_idx       <= '0;
              bus.busy       <= 1'b1;
              bus.byte_ready <= 1'b1;
              state          <= COLLECT;
            end else begin
              bus.error <= 1'b1;
            end
          end
        end

        COLLECT: begin
          if (bus.abort) begin
            bus.busy       <= 1'b0;
            bus.byte_ready <= 1'b0;
            state          <= IDLE;
          end else if (accept) begin
            word_q[{byte_idx, 3'b000} +: 8] <= bus.byte_in;
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              bus.byte_ready <= 1'b0;
              state          <= WRITE;
            end
          end
        end

        WRITE: begin
          // Abort wins over the write strobe: the partial program stops here.
          if (bus.abort) begin
            bus.busy       <= 1'b0;
            bus.byte_ready <= 1'b0;
            state          <= IDLE;
          end else begin
            bus.mem_we    <= 1'b1;
            bus.mem_addr  <= addr_q;
            bus.mem_wdata <= word_q;
            if (last_word) begin
              state <= DONE;
            end else begin
              addr_q         <= addr_q + ADDR_W'(1);
              bus.byte_ready <= 1'b1;
              state          <= COLLECT;
            end
          end
        end

        DONE: begin
          // busy stays high through the done pulse and drops on the IDLE edge.
          bus.done <= 1'b1;
          state    <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table-driven single-word and illegal-count
// vectors, then hand-written full-load, stall, abort, start-while-busy and reset sequences.
module tb_imem_loader;
  logic clock;
  logic reset_;

  imem_loader_if #(.ADDR_W(6)) bus ();

  imem_loader #(.ADDR_W(6), .DEPTH(64)) dut (
    .clock  (clock),
    .reset_ (reset_),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // Reference instruction memory plus write/pulse monitors, sampled on the falling edge.
  logic [31:0] ref_mem [64];
  int          cyc = 0;
  int          nwrites = 0;
  int          ndone = 0;
  int          nerr = 0;
  int          done_cyc = 0;
  int          ooo = 0;
  int          wide = 0;
  logic [5:0]  exp_addr = '0;
  logic [5:0]  last_addr = '0;
  logic [31:0] last_data = '0;
  logic        prev_done = 1'b0;
  logic        prev_error = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (bus.mem_we) begin
      ref_mem[bus.mem_addr] = bus.mem_wdata;
      if (bus.mem_addr !== exp_addr) ooo++;
      exp_addr  = exp_addr + 6'd1;
      last_addr = bus.mem_addr;
      last_data = bus.mem_wdata;
      nwrites++;
    end
    if (bus.done) begin
      ndone++;
      done_cyc = cyc;
    end
    if (bus.error) nerr++;
    if ((bus.done && prev_done) || (bus.error && prev_error)) wide++;
    prev_done  = bus.done;
    prev_error = bus.error;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(negedge clock);
    #1;
  endtask

  int          s_cyc;
  logic [7:0]  bq [$];

  task automatic do_start(input logic [6:0] cnt);
    bus.start      = 1'b1;
    bus.word_count = cnt;
    exp_addr       = '0;
    tick;
    bus.start = 1'b0;
    s_cyc     = cyc;
  endtask

  task automatic feed(input int valid_pct, input int budget);
    logic rdy;
    logic v;
    while (bq.size() > 0 && budget > 0) begin
      rdy            = bus.byte_ready;
      v              = ($urandom_range(99) < valid_pct);
      bus.byte_valid = v;
      bus.byte_in    = bq[0];
      tick;
      if (v && rdy) void'(bq.pop_front());
      budget--;
    end
    bus.byte_valid = 1'b0;
    if (bq.size() > 0) begin
      check("feed budget", bq.size(), 0);
      bq.delete();
    end
  endtask

  task automatic wait_done(input int d0, input int budget);
    while (ndone == d0 && budget > 0) begin
      tick;
      budget--;
    end
    check("done seen", ndone - d0, 1);
  endtask

  typedef struct {
    logic [6:0]  cnt;
    logic [31:0] stream;   // send order: [31:24] first
    logic        exp_err;
    logic [31:0] exp_word;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int w0, d0, e0, bad;
    logic [31:0] ew;

    vecs[0] = '{7'd1,   32'h13005000, 1'b0, 32'h00500013};
    vecs[1] = '{7'd0,   32'h0,        1'b1, 32'h0};
    vecs[2] = '{7'd1,   32'hDEADBEEF, 1'b0, 32'hEFBEADDE};
    vecs[3] = '{7'd65,  32'h0,        1'b1, 32'h0};
    vecs[4] = '{7'd1,   32'h01020304, 1'b0, 32'h04030201};
    vecs[5] = '{7'd127, 32'h0,        1'b1, 32'h0};

    reset_         = 1'b0;
    bus.start      = 1'b0;
    bus.word_count = '0;
    bus.abort      = 1'b0;
    bus.byte_in    = '0;
    bus.byte_valid = 1'b0;
    tick;
    tick;
    check("rst busy",       bus.busy,       0);
    check("rst byte_ready", bus.byte_ready, 0);
    check("rst mem_we",     bus.mem_we,     0);
    check("rst done",       bus.done,       0);
    check("rst error",      bus.error,      0);
    check("rst mem_addr",   bus.mem_addr,   0);
    check("rst mem_wdata",  bus.mem_wdata,  0);
    reset_ = 1'b1;
    tick;

    // Table-driven single-word loads and illegal counts.
    for (int v = 0; v < 6; v++) begin
      w0 = nwrites; d0 = ndone; e0 = nerr;
      do_start(vecs[v].cnt);
      if (vecs[v].exp_err) begin
        check("err pulse",    nerr - e0,  1);
        check("err busy",     bus.busy,   0);
        tick;
        check("err width",    bus.error,  0);
        check("err no write", nwrites - w0, 0);
      end else begin
        check("vec busy",  bus.busy,       1);
        check("vec ready", bus.byte_ready, 1);
        for (int b = 0; b < 4; b++) bq.push_back(vecs[v].stream[31-8*b -: 8]);
        feed(100, 50);
        wait_done(d0, 50);
        check("vec latency",    done_cyc - s_cyc, 6);
        check("vec busy@done",  bus.busy,   1);
        check("vec writes",     nwrites - w0, 1);
        check("vec addr",       last_addr,  0);
        check("vec wdata",      last_data,  vecs[v].exp_word);
        tick;
        check("vec busy fall",  bus.busy,   0);
        check("vec done width", bus.done,   0);
      end
    end

    // Full 64-word load with bytes 00..FF.
    w0 = nwrites; d0 = ndone;
    do_start(7'd64);
    for (int i = 0; i < 256; i++) bq.push_back(8'(i));
    feed(100, 400);
    wait_done(d0, 20);
    check("full latency", done_cyc - s_cyc, 321);
    check("full writes",  nwrites - w0, 64);
    check("full last addr", last_addr, 63);
    check("full word0",   ref_mem[0],  32'h03020100);
    check("full word63",  ref_mem[63], 32'hFFFEFDFC);
    bad = 0;
    for (int k = 0; k < 64; k++) begin
      ew = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
      if (ref_mem[k] !== ew) bad++;
    end
    check("full readback", bad, 0);
    repeat (5) tick;
    check("full single done", ndone - d0, 1);
    check("full no extra write", nwrites - w0, 64);

    // Random stalls on a two-word load.
    w0 = nwrites; d0 = ndone;
    do_start(7'd2);
    bq = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22, 8'h33, 8'h44};
    feed(50, 200);
    wait_done(d0, 20);
    check("stall writes", nwrites - w0, 2);
    check("stall word0",  ref_mem[0], 32'hDDCCBBAA);
    check("stall word1",  ref_mem[1], 32'h44332211);

    // Abort in COLLECT after six bytes, then a fresh load restarts at 0.
    w0 = nwrites; d0 = ndone;
    do_start(7'd3);
    bq = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
    feed(100, 30);
    bus.abort = 1'b1;
    tick;
    bus.abort = 1'b0;
    check("abort busy",  bus.busy,       0);
    check("abort ready", bus.byte_ready, 0);
    repeat (8) tick;
    check("abort writes", nwrites - w0, 1);
    check("abort word0",  ref_mem[0], 32'h13121110);
    check("abort no done", ndone - d0, 0);
    w0 = nwrites; d0 = ndone;
    do_start(7'd1);
    bq = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    feed(100, 30);
    wait_done(d0, 20);
    check("restart addr", last_addr, 0);
    check("restart data", last_data, 32'hA3A2A1A0);
    check("restart writes", nwrites - w0, 1);

    // Abort on the WRITE cycle suppresses the strobe.
    w0 = nwrites; d0 = ndone;
    do_start(7'd2);
    bq = '{8'h01, 8'h02, 8'h03, 8'h04};
    feed(100, 30);
    bus.abort = 1'b1;
    tick;
    bus.abort = 1'b0;
    repeat (6) tick;
    check("abort write no we", nwrites - w0, 0);
    check("abort write no done", ndone - d0, 0);
    check("abort write busy", bus.busy, 0);

    // start while busy is ignored; count stays 2.
    w0 = nwrites; d0 = ndone;
    do_start(7'd2);
    bq = '{8'h55, 8'h66, 8'h77, 8'h88};
    feed(100, 30);
    bus.start      = 1'b1;
    bus.word_count = 7'd1;
    tick;
    bus.start = 1'b0;
    check("busy start ignored", bus.busy, 1);
    bq = '{8'h99, 8'hAA, 8'hBB, 8'hCC};
    feed(100, 30);
    wait_done(d0, 20);
    check("busy start latency", done_cyc - s_cyc, 11);
    check("busy start writes",  nwrites - w0, 2);
    check("busy start word1",   ref_mem[1], 32'hCCBBAA99);

    // Reset in the middle of word 1.
    w0 = nwrites; d0 = ndone;
    do_start(7'd2);
    bq = '{8'hE0, 8'hE1, 8'hE2, 8'hE3, 8'hE4, 8'hE5};
    feed(100, 30);
    reset_ = 1'b0;
    #1;
    check("mid rst busy",      bus.busy,       0);
    check("mid rst ready",     bus.byte_ready, 0);
    check("mid rst mem_we",    bus.mem_we,     0);
    check("mid rst mem_wdata", bus.mem_wdata,  0);
    check("mid rst mem_addr",  bus.mem_addr,   0);
    tick;
    reset_ = 1'b1;
    repeat (8) tick;
    check("mid rst writes", nwrites - w0, 1);
    check("mid rst last addr", last_addr, 0);
    check("mid rst no done", ndone - d0, 0);

    check("write order", ooo, 0);
    check("pulse width", wide, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
